// File: rtl/ram_fifo_ctrl.sv
// FIFO controller backed by an external single-port RAM with a bidirectional data bus.
// Every RAM access is exactly two cycles, and the head-of-queue byte is staged in POP_DATA.
module ram_fifo_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AW    = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PUSH_VALID,
    input  logic [WIDTH-1:0] PUSH_DATA,
    output logic             PUSH_READY,
    output logic             POP_VALID,
    output logic [WIDTH-1:0] POP_DATA,
    input  logic             POP_READY,
    output logic [AW:0]      COUNT,
    output logic             FULL,
    output logic             EMPTY,
    output logic             RAM_CS,
    output logic             RAM_W_EN,
    output logic             RAM_RWS,
    output logic [AW-1:0]    RAM_ADDR,
    inout  wire  [WIDTH-1:0] RAM_IO
);

    localparam int unsigned DEPTH    = 2 ** AW;
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

    typedef enum logic [2:0] {
        IDLE,
        WR1,
        WR2,
        RD1,
        RD2
    } state_t;

    state_t           state;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] wdata;
    logic             need_fetch;

    assign need_fetch = !POP_VALID && (COUNT != '0);
    assign PUSH_READY = (state == IDLE) && (COUNT != CNT_FULL) && !need_fetch;
    assign FULL       = (COUNT == CNT_FULL);
    assign EMPTY      = (COUNT == '0) && !POP_VALID;

    // RAM_RWS is high exactly in WR1/WR2, so it doubles as the bus-drive enable.
    assign RAM_IO = RAM_RWS ? wdata : 'z;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wdata     <= '0;
            COUNT     <= '0;
            POP_VALID <= 1'b0;
            POP_DATA  <= '0;
            RAM_CS    <= 1'b0;
            RAM_W_EN  <= 1'b0;
            RAM_RWS   <= 1'b0;
            RAM_ADDR  <= '0;
        end else begin
            if (POP_VALID && POP_READY) begin
                POP_VALID <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (need_fetch) begin
                        state    <= RD1;
                        RAM_CS   <= 1'b1;
                        RAM_W_EN <= 1'b0;
                        RAM_RWS  <= 1'b0;
                        RAM_ADDR <= rd_ptr;
                    end else if (PUSH_VALID && PUSH_READY) begin
                        state    <= WR1;
                        wdata    <= PUSH_DATA;
                        RAM_CS   <= 1'b1;
                        RAM_W_EN <= 1'b1;
                        RAM_RWS  <= 1'b1;
                        RAM_ADDR <= wr_ptr;
                    end
                end

                WR1: state <= WR2;

                WR2: begin
                    state    <= IDLE;
                    wr_ptr   <= wr_ptr + AW'(1);
                    COUNT    <= COUNT + (AW + 1)'(1);
                    RAM_CS   <= 1'b0;
                    RAM_W_EN <= 1'b0;
                    RAM_RWS  <= 1'b0;
                end

                RD1: state <= RD2;

                RD2: begin
                    state     <= IDLE;
                    POP_DATA  <= RAM_IO;
                    POP_VALID <= 1'b1;
                    rd_ptr    <= rd_ptr + AW'(1);
                    COUNT     <= COUNT - (AW + 1)'(1);
                    RAM_CS    <= 1'b0;
                    RAM_W_EN  <= 1'b0;
                    RAM_RWS   <= 1'b0;
                end

                default: begin
                    state    <= IDLE;
                    RAM_CS   <= 1'b0;
                    RAM_W_EN <= 1'b0;
                    RAM_RWS  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed bench for ram_fifo_ctrl with a behavioural RAM on the bidirectional bus.
module tb_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push_valid = 1'b0;
    logic [7:0] push_data = '0;
    logic       push_ready;
    logic       pop_valid;
    logic [7:0] pop_data;
    logic       pop_ready = 1'b0;
    logic [5:0] count;
    logic       full;
    logic       empty;
    logic       ram_cs;
    logic       ram_w_en;
    logic       ram_rws;
    logic [4:0] ram_addr;
    wire  [7:0] ram_io;

    logic [7:0] mem [32];

    int vecs = 0;
    int errs = 0;

    ram_fifo_ctrl #(.WIDTH(8), .AW(5)) dut (
        .CLK(clk), .RST(rst),
        .PUSH_VALID(push_valid), .PUSH_DATA(push_data), .PUSH_READY(push_ready),
        .POP_VALID(pop_valid), .POP_DATA(pop_data), .POP_READY(pop_ready),
        .COUNT(count), .FULL(full), .EMPTY(empty),
        .RAM_CS(ram_cs), .RAM_W_EN(ram_w_en), .RAM_RWS(ram_rws),
        .RAM_ADDR(ram_addr), .RAM_IO(ram_io)
    );

    always #5 clk = ~clk;

    // RAM model: drives the bus only for selected reads, stores on write cycles.
    assign ram_io = (ram_cs && !ram_rws) ? mem[ram_addr] : 'z;
    always @(posedge clk) begin
        if (ram_cs && ram_w_en) mem[ram_addr] <= ram_io;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        push_valid = 1'b0;
        pop_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic push_byte(input logic [7:0] d);
        int n = 0;
        push_valid = 1'b1;
        push_data  = d;
        while (!push_ready && n < 40) begin
            step();
            n++;
        end
        vecs++;
        if (!push_ready) begin
            errs++;
            $display("FAIL push_timeout data=%h push_ready=%b required 1", d, push_ready);
        end else begin
            step();
        end
        push_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        vecs++; if (count !== 6'd0)   begin errs++; $display("FAIL rst_count got %0d want 0", count); end
        vecs++; if (pop_valid !== 0)  begin errs++; $display("FAIL rst_pop_valid got %b want 0", pop_valid); end
        vecs++; if (pop_data !== 0)   begin errs++; $display("FAIL rst_pop_data got %h want 00", pop_data); end
        vecs++; if (ram_addr !== 0)   begin errs++; $display("FAIL rst_ram_addr got %0d want 0", ram_addr); end
        vecs++; if (ram_cs !== 0)     begin errs++; $display("FAIL rst_ram_cs got %b want 0", ram_cs); end
        vecs++; if (ram_w_en !== 0)   begin errs++; $display("FAIL rst_ram_w_en got %b want 0", ram_w_en); end
        vecs++; if (ram_rws !== 0)    begin errs++; $display("FAIL rst_ram_rws got %b want 0", ram_rws); end
        vecs++; if (full !== 0)       begin errs++; $display("FAIL rst_full got %b want 0", full); end
        vecs++; if (empty !== 1)      begin errs++; $display("FAIL rst_empty got %b want 1", empty); end
        vecs++; if (push_ready !== 1) begin errs++; $display("FAIL rst_push_ready got %b want 1", push_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_byte();
        // edge N: handshake presented, captured at edge N+1
        push_valid = 1'b1; push_data = 8'hA5;
        vecs++; if (push_ready !== 1) begin errs++; $display("FAIL single_ready got %b want 1", push_ready); end
        step(); push_valid = 1'b0;                                   // N+1
        vecs++; if ({ram_cs, ram_w_en, ram_rws} !== 3'b111) begin errs++; $display("FAIL single_wr1_ctl got %b want 111", {ram_cs, ram_w_en, ram_rws}); end
        vecs++; if (ram_addr !== 5'd0) begin errs++; $display("FAIL single_wr1_addr got %0d want 0", ram_addr); end
        step();                                                      // N+2
        vecs++; if (ram_rws !== 1 || ram_addr !== 0) begin errs++; $display("FAIL single_wr2 got rws=%b addr=%0d want rws=1 addr=0", ram_rws, ram_addr); end
        vecs++; if (count !== 6'd0) begin errs++; $display("FAIL single_cnt_wr2 got %0d want 0", count); end
        step();                                                      // N+3
        vecs++; if (count !== 6'd1) begin errs++; $display("FAIL single_cnt_n3 got %0d want 1", count); end
        vecs++; if (ram_cs !== 0 || empty !== 0) begin errs++; $display("FAIL single_idle got cs=%b empty=%b want cs=0 empty=0", ram_cs, empty); end
        step();                                                      // N+4
        vecs++; if ({ram_cs, ram_w_en, ram_rws} !== 3'b100) begin errs++; $display("FAIL single_rd1_ctl got %b want 100", {ram_cs, ram_w_en, ram_rws}); end
        step();                                                      // N+5
        vecs++; if (pop_valid !== 0) begin errs++; $display("FAIL single_early_valid got %b want 0", pop_valid); end
        step();                                                      // N+6
        vecs++; if (pop_valid !== 1) begin errs++; $display("FAIL single_pop_valid got %b want 1", pop_valid); end
        vecs++; if (pop_data !== 8'hA5) begin errs++; $display("FAIL single_pop_data got %h want a5", pop_data); end
        vecs++; if (count !== 6'd0) begin errs++; $display("FAIL single_cnt_n6 got %0d want 0", count); end
        vecs++; if (mem[0] !== 8'hA5) begin errs++; $display("FAIL single_ram_word got %h want a5", mem[0]); end
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
        vecs++; if (pop_valid !== 0 || empty !== 1) begin errs++; $display("FAIL single_popped got valid=%b empty=%b want 0 1", pop_valid, empty); end
        vecs++; if (pop_data !== 8'hA5) begin errs++; $display("FAIL single_hold got %h want a5", pop_data); end
    endtask

    task automatic test_fill();
        int e = 0;
        pop_ready = 1'b0;
        for (int i = 0; i < 33; i++) push_byte(8'(i));
        repeat (8) step();
        vecs++; if (full !== 1) begin errs++; $display("FAIL fill_full got %b want 1", full); end
        vecs++; if (count !== 6'd32) begin errs++; $display("FAIL fill_count got %0d want 32", count); end
        vecs++; if (pop_valid !== 1 || pop_data !== 8'h00) begin errs++; $display("FAIL fill_head got valid=%b data=%h want 1 00", pop_valid, pop_data); end
        vecs++; if (push_ready !== 0) begin errs++; $display("FAIL fill_ready got %b want 0", push_ready); end
        push_valid = 1'b1; push_data = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            step();
            vecs++; if (push_ready !== 0 || ram_cs !== 0) begin errs++; $display("FAIL fill_ignore got ready=%b cs=%b want 0 0", push_ready, ram_cs); end
        end
        push_valid = 1'b0;
        vecs++; if (count !== 6'd32) begin errs++; $display("FAIL fill_count_hold got %0d want 32", count); end
        pop_ready = 1'b1;
        for (int c = 0; c < 400 && e < 33; c++) begin
            if (pop_valid) begin
                vecs++; if (pop_data !== 8'(e)) begin errs++; $display("FAIL fill_drain got %h want %h", pop_data, 8'(e)); end
                e++;
            end
            step();
        end
        pop_ready = 1'b0;
        repeat (6) step();
        vecs++; if (e !== 33) begin errs++; $display("FAIL fill_drain_len got %0d want 33", e); end
        vecs++; if (pop_valid !== 0 || empty !== 1 || full !== 0) begin errs++; $display("FAIL fill_end got valid=%b empty=%b full=%b want 0 1 0", pop_valid, empty, full); end
    endtask

    task automatic test_wrap();
        int idx = 0;
        int popped = 0;
        pop_ready = 1'b1;
        for (int c = 0; c < 2000 && popped < 40; c++) begin
            push_valid = (idx < 40);
            push_data  = 8'h10 + 8'(idx);
            if (pop_valid) begin
                vecs++; if (pop_data !== 8'h10 + 8'(popped)) begin errs++; $display("FAIL wrap_order got %h want %h", pop_data, 8'h10 + 8'(popped)); end
                popped++;
            end
            if (push_valid && push_ready) idx++;
            step();
        end
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        repeat (6) step();
        vecs++; if (popped !== 40) begin errs++; $display("FAIL wrap_count got %0d want 40", popped); end
        vecs++; if (empty !== 1 || count !== 0) begin errs++; $display("FAIL wrap_end got empty=%b count=%0d want 1 0", empty, count); end
    endtask

    task automatic test_priority();
        apply_reset();
        for (int i = 0; i < 4; i++) push_byte(8'h41 + 8'(i));
        repeat (6) step();
        vecs++; if (count !== 6'd3 || pop_data !== 8'h41) begin errs++; $display("FAIL prio_setup got count=%0d data=%h want 3 41", count, pop_data); end
        pop_ready = 1'b1;
        step();
        pop_ready = 1'b0;
        push_valid = 1'b1; push_data = 8'h55;
        vecs++; if (pop_valid !== 0 || count !== 6'd3) begin errs++; $display("FAIL prio_state got valid=%b count=%0d want 0 3", pop_valid, count); end
        vecs++; if (push_ready !== 0) begin errs++; $display("FAIL prio_ready got %b want 0", push_ready); end
        step();
        vecs++; if ({ram_cs, ram_rws} !== 2'b10 || ram_addr !== 5'd1) begin errs++; $display("FAIL prio_rd1 got cs_rws=%b addr=%0d want 10 1", {ram_cs, ram_rws}, ram_addr); end
        vecs++; if (push_ready !== 0) begin errs++; $display("FAIL prio_ready_rd got %b want 0", push_ready); end
        step();
        step();
        vecs++; if (pop_valid !== 1 || pop_data !== 8'h42 || count !== 6'd2) begin errs++; $display("FAIL prio_fetch got valid=%b data=%h count=%0d want 1 42 2", pop_valid, pop_data, count); end
        vecs++; if (push_ready !== 1) begin errs++; $display("FAIL prio_ready_idle got %b want 1", push_ready); end
        step();
        push_valid = 1'b0;
        vecs++; if (ram_rws !== 1 || ram_addr !== 5'd4) begin errs++; $display("FAIL prio_push got rws=%b addr=%0d want 1 4", ram_rws, ram_addr); end
        step();
        step();
        vecs++; if (count !== 6'd3 || mem[4] !== 8'h55) begin errs++; $display("FAIL prio_stored got count=%0d mem=%h want 3 55", count, mem[4]); end
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        push_valid = 1'b1; push_data = 8'h77;
        step();
        push_valid = 1'b0;
        step();
        vecs++; if (ram_rws !== 1) begin errs++; $display("FAIL rstw_in_wr2 got %b want 1", ram_rws); end
        #2 rst = 1'b1;
        #1;
        vecs++; if (ram_cs !== 0 || ram_rws !== 0 || ram_w_en !== 0) begin errs++; $display("FAIL rstw_abort got %b want 000", {ram_cs, ram_w_en, ram_rws}); end
        vecs++; if (count !== 0 || empty !== 1) begin errs++; $display("FAIL rstw_count got count=%0d empty=%b want 0 1", count, empty); end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) step();
        vecs++; if (pop_valid !== 0 || count !== 0 || ram_cs !== 0) begin errs++; $display("FAIL rstw_lost got valid=%b count=%0d cs=%b want 0 0 0", pop_valid, count, ram_cs); end
    endtask

    task automatic test_random();
        logic [7:0] sb [$];
        logic [7:0] exp;
        apply_reset();
        for (int c = 0; c < 2000; c++) begin
            push_valid = 1'($urandom_range(0, 1));
            push_data  = 8'($urandom);
            pop_ready  = 1'($urandom_range(0, 2) == 0);
            if (push_valid && push_ready) sb.push_back(push_data);
            if (pop_valid && pop_ready) begin
                exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
                vecs++; if (pop_data !== exp) begin errs++; $display("FAIL rand_order got %h want %h", pop_data, exp); end
            end
            vecs++;
            if (count > 6'd32 || (ram_rws && !(ram_cs && ram_w_en)) || (!ram_cs && ram_rws)) begin
                errs++;
                $display("FAIL rand_bus got count=%0d cs=%b wen=%b rws=%b want count<=32 rws only in writes", count, ram_cs, ram_w_en, ram_rws);
            end
            step();
        end
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        for (int c = 0; c < 600 && (sb.size() != 0 || pop_valid); c++) begin
            if (pop_valid) begin
                exp = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
                vecs++; if (pop_data !== exp) begin errs++; $display("FAIL rand_drain got %h want %h", pop_data, exp); end
            end
            step();
        end
        pop_ready = 1'b0;
        vecs++; if (sb.size() != 0 || empty !== 1) begin errs++; $display("FAIL rand_end got left=%0d empty=%b want 0 1", sb.size(), empty); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        test_reset();
        test_single_byte();
        test_fill();
        test_wrap();
        test_priority();
        test_reset_mid_write();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, data width of the FIFO and of the RAM IO bus.
REQ-002 Parameter: AW, 5, RAM address width; depth is 2**AW = 32 words.
REQ-003 Reset is asynchronous and active-high; single clock CLK; ports CLK, RST.
REQ-004 CLK  in  1  rising-edge clock for all state.
REQ-005 RST  in  1  asynchronous active-high reset.
REQ-006 PUSH_VALID  in  1  producer has a byte on PUSH_DATA.
REQ-007 PUSH_DATA  in  WIDTH  byte to store.
REQ-008 PUSH_READY  out  1  controller accepts PUSH_DATA this cycle.
REQ-009 POP_VALID  out  1  POP_DATA holds the oldest byte.
REQ-010 POP_DATA  out  WIDTH  registered head-of-FIFO byte.
REQ-011 POP_READY  in  1  consumer takes POP_DATA this cycle.
REQ-012 COUNT  out  AW+1  bytes resident in RAM (0..32), excluding POP_DATA register.
REQ-013 FULL  out  1  COUNT == 32.
REQ-014 EMPTY  out  1  COUNT == 0 and POP_VALID == 0.
REQ-015 RAM_CS  out  1  RAM chip select.
REQ-016 RAM_W_EN  out  1  RAM write enable.
REQ-017 RAM_RWS  out  1  RAM direction, 1 = write (controller drives IO), 0 = read.
REQ-018 RAM_ADDR  out  AW  RAM word address.
REQ-019 RAM_IO  inout  WIDTH  RAM bidirectional data bus.

Function
REQ-020 FSM states IDLE, WR1, WR2, RD1, RD2; encoding free; every access is exactly 2 cycles.
REQ-021 Internal: WR_PTR, RD_PTR (AW bits, wrap 31 -> 0 modulo 32), COUNT, write-data register WDATA.
REQ-022 NEED_FETCH = (POP_VALID == 0) and (COUNT != 0).
REQ-023 PUSH_READY = (state == IDLE) and (COUNT != 32) and not NEED_FETCH; combinational, no dependence on PUSH_VALID.
REQ-024 IDLE: NEED_FETCH -> RD1 (fetch has priority); else PUSH_VALID and PUSH_READY -> WDATA <= PUSH_DATA, -> WR1; else stay.
REQ-025 WR1, WR2: RAM_CS=1, RAM_W_EN=1, RAM_RWS=1, RAM_ADDR=WR_PTR, RAM_IO driven with WDATA.
REQ-026 End of WR2: WR_PTR+1, COUNT+1, -> IDLE.
REQ-027 RD1, RD2: RAM_CS=1, RAM_W_EN=0, RAM_RWS=0, RAM_ADDR=RD_PTR, RAM_IO released (high-Z).
REQ-028 End of RD2: POP_DATA <= RAM_IO, POP_VALID <= 1, RD_PTR+1, COUNT-1, -> IDLE.
REQ-029 IDLE: RAM_CS=0, RAM_W_EN=0, RAM_RWS=0, RAM_IO high-Z, RAM_ADDR holds last value.
REQ-030 RAM_IO is driven only in WR1/WR2; never driven in the cycle that RAM_RWS is 0.
REQ-031 Pop handshake: POP_VALID and POP_READY at an edge clears POP_VALID; accepted in any FSM state; POP_DATA holds its value until the next RD2.
REQ-032 Push latency: accepted at edge N, COUNT increments at edge N+3; into empty FIFO POP_VALID rises at edge N+6.
REQ-033 Full: COUNT == 32 -> PUSH_READY=0, PUSH_DATA ignored, no pointer or COUNT change.
REQ-034 Empty: COUNT == 0 -> no RAM read issued; pop with POP_VALID=0 has no effect.
REQ-035 Capacity: 32 in RAM plus 1 in POP_DATA = 33 bytes total.
REQ-036 Order: bytes leave POP_DATA in exact push order across pointer wrap-around.

Reset
REQ-037 RST high, asynchronously: state IDLE, WR_PTR=0, RD_PTR=0, COUNT=0, POP_VALID=0, POP_DATA=0, WDATA=0, RAM_ADDR=0, RAM_CS=0, RAM_W_EN=0, RAM_RWS=0, RAM_IO high-Z, FULL=0, EMPTY=1.
REQ-038 RST asserted during WR1/WR2/RD1/RD2 aborts the access immediately; the interrupted byte is lost and counters are not updated.

Verification
REQ-039 Reset: RST pulse mid-WR2 -> RAM_CS=0 and RAM_IO=Z before the next edge; COUNT=0, EMPTY=1.
REQ-040 Single byte: push 8'hA5 into empty FIFO at edge N -> RAM_ADDR=0, RAM_RWS=1 on N+1..N+2; POP_VALID=1, POP_DATA=8'hA5 after N+6; COUNT=0.
REQ-041 Fill: push 33 bytes 0..32 with POP_READY=0 -> FULL=1, COUNT=32, POP_DATA=0, PUSH_READY=0; 34th byte ignored.
REQ-042 Wrap: 40 bytes 8'h10..8'h37 pushed with POP_READY=1 throughout -> pop sequence identical, pointers pass 31 -> 0, no loss or duplication.
REQ-043 Bus: random push/pop for 2000 cycles -> RAM_IO never driven while RAM_RWS=0; scoreboard order matches; COUNT never exceeds 32.
REQ-044 Priority: POP_VALID=0, COUNT=3, PUSH_VALID=1 in IDLE -> PUSH_READY=0, FSM enters RD1; push accepted on first IDLE afterwards.
